// File: rtl/training_sample_feeder.sv
// training_sample_feeder - training-set RAM that serves one (x1, x2, t) sample per controller request.
// Optional build macro FEEDER_EPOCH_LIMIT_EN enables the sticky epoch limit (MAX_EPOCHS).
module training_sample_feeder #(
  parameter int DATA_W  = 8,
  parameter int T_W     = 2,
  parameter int ADDR_W  = 4,
  parameter int EPOCH_W = 8
`ifdef FEEDER_EPOCH_LIMIT_EN
  , parameter int MAX_EPOCHS = 50
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_x1,
  input  logic [DATA_W-1:0] load_x2,
  input  logic [T_W-1:0]    load_t,
  input  logic [ADDR_W:0]   n_samples,
  input  logic              rewind,
  input  logic              req,
  output logic              data_ready,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [T_W-1:0]    t,
  output logic              eof,
  output logic              empty,
  output logic [ADDR_W-1:0] sample_idx,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic              limit_hit
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   n_lat;
  logic              blocked;
  logic              ptr_is_last;

  logic [DATA_W-1:0] mem_x1 [DEPTH];
  logic [DATA_W-1:0] mem_x2 [DEPTH];
  logic [T_W-1:0]    mem_t  [DEPTH];

  assign empty       = (n_samples == '0);
  assign ptr_is_last = ({1'b0, ptr} == (n_lat - (ADDR_W+1)'(1)));

`ifdef FEEDER_EPOCH_LIMIT_EN
  logic limit_q;
  assign limit_hit = limit_q;
  assign blocked   = limit_q;
`else
  assign limit_hit = 1'b0;
  assign blocked   = 1'b0;
`endif

  // Write port has no reset: RAM contents are undefined after rst.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_x1[load_addr] <= load_x1;
      mem_x2[load_addr] <= load_x2;
      mem_t[load_addr]  <= load_t;
    end
  end

  // The FETCH->PRESENT edge is the synchronous RAM read; reading in the same
  // edge as a write gives read-before-write for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      n_lat      <= '0;
      data_ready <= 1'b0;
      x1         <= '0;
      x2         <= '0;
      t          <= '0;
      eof        <= 1'b0;
      sample_idx <= '0;
      epoch_cnt  <= '0;
`ifdef FEEDER_EPOCH_LIMIT_EN
      limit_q    <= 1'b0;
`endif
    end else if (rewind) begin
      state      <= IDLE;
      data_ready <= 1'b0;
      ptr        <= '0;
      epoch_cnt  <= '0;
`ifdef FEEDER_EPOCH_LIMIT_EN
      limit_q    <= 1'b0;
`endif
    end else begin
      data_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !empty && !blocked) begin
            state <= FETCH;
            n_lat <= n_samples;
            if (n_samples <= {1'b0, ptr}) ptr <= '0;
          end
        end
        FETCH: begin
          state      <= PRESENT;
          x1         <= mem_x1[ptr];
          x2         <= mem_x2[ptr];
          t          <= mem_t[ptr];
          eof        <= ptr_is_last;
          sample_idx <= ptr;
          data_ready <= 1'b1;
        end
        PRESENT: begin
          state <= IDLE;
          if (ptr_is_last) begin
            ptr       <= '0;
            epoch_cnt <= epoch_cnt + 1'b1;
`ifdef FEEDER_EPOCH_LIMIT_EN
            if (epoch_cnt + 1'b1 == EPOCH_W'(MAX_EPOCHS)) limit_q <= 1'b1;
`endif
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_training_sample_feeder.sv
// tb_training_sample_feeder - scoreboard bench for training_sample_feeder (default build).
module tb_training_sample_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_x1, load_x2;
  logic [1:0] load_t;
  logic [4:0] n_samples;
  logic       rewind, req;
  logic       data_ready, eof, empty, limit_hit;
  logic [7:0] x1, x2;
  logic [1:0] t;
  logic [3:0] sample_idx;
  logic [7:0] epoch_cnt;

  training_sample_feeder dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_x1(load_x1), .load_x2(load_x2), .load_t(load_t), .n_samples(n_samples),
    .rewind(rewind), .req(req), .data_ready(data_ready), .x1(x1), .x2(x2), .t(t),
    .eof(eof), .empty(empty), .sample_idx(sample_idx), .epoch_cnt(epoch_cnt),
    .limit_hit(limit_hit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x1;
    logic [7:0] x2;
    logic [1:0] t;
    logic       eof;
    logic [3:0] idx;
    logic [7:0] ep;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int strobes = 0;

  localparam logic [1:0] TP = 2'b01;
  localparam logic [1:0] TN = 2'b11;

  task automatic chk(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
    end
  endtask

  task automatic push(input int idx, input int a, input int b, input logic [1:0] tt,
                      input logic e, input int ep);
    exp_t s;
    s.x1 = 8'(a); s.x2 = 8'(b); s.t = tt; s.eof = e; s.idx = 4'(idx); s.ep = 8'(ep);
    exp_q.push_back(s);
  endtask

  // Monitor: every strobe pops one expected sample.
  always @(negedge clk) begin
    if (!rst && data_ready) begin
      exp_t got, e;
      strobes++;
      checks++;
      got = {x1, x2, t, eof, sample_idx, epoch_cnt};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe actual idx=%0d x1=%0d required no strobe", sample_idx, $signed(x1));
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL sample actual idx=%0d x1=%0d x2=%0d t=%0d eof=%0d ep=%0d required idx=%0d x1=%0d x2=%0d t=%0d eof=%0d ep=%0d",
                   got.idx, $signed(got.x1), $signed(got.x2), got.t, got.eof, got.ep,
                   e.idx, $signed(e.x1), $signed(e.x2), e.t, e.eof, e.ep);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int a, input int v1, input int v2, input logic [1:0] tt);
    load_en = 1'b1; load_addr = 4'(a); load_x1 = 8'(v1); load_x2 = 8'(v2); load_t = tt;
    tick(1);
    load_en = 1'b0;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(4);
  endtask

  initial begin
    int base, cyc;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_x1 = '0; load_x2 = '0; load_t = '0;
    n_samples = '0; rewind = 1'b0; req = 1'b0;
    tick(2);
    @(negedge clk);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_outputs", {x1, x2, t, eof, sample_idx}, 0);
    chk("rst_epoch", epoch_cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_limit", limit_hit, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    load(0, 10, -20, TP);
    load(1, 30, 40, TN);
    load(2, -5, 7, TP);

    // Empty set: requests ignored for 20 cycles.
    base = strobes;
    req = 1'b1;
    tick(20);
    req = 1'b0;
    chk("empty_flag", empty, 1);
    chk("empty_no_strobe", strobes - base, 0);
    chk("empty_eof", eof, 0);

    // Held req: one sample every 3 cycles, wrap with epoch increment.
    n_samples = 5'd3;
    chk("nonempty_flag", empty, 0);
    push(0, 10, -20, TP, 0, 0);
    push(1, 30, 40, TN, 0, 0);
    push(2, -5, 7, TP, 1, 0);
    push(0, 10, -20, TP, 0, 1);
    base = strobes; cyc = 0;
    req = 1'b1;
    while (strobes - base < 4 && cyc < 40) begin tick(1); cyc++; end
    req = 1'b0;
    chk("held_req_cycles", cyc, 12);
    chk("epoch_after_wrap", epoch_cnt, 1);
    tick(3);

    // Single-cycle req pulse dropped in FETCH still yields exactly one sample.
    base = strobes;
    push(1, 30, 40, TN, 0, 1);
    pulse_req();
    tick(5);
    chk("pulse_one_strobe", strobes - base, 1);

    // Overwrite the addressed sample during FETCH: old data is presented.
    push(2, -5, 7, TP, 1, 1);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    load_en = 1'b1; load_addr = 4'd2; load_x1 = 8'd99; load_x2 = 8'(-99); load_t = TN;
    tick(1);
    load_en = 1'b0;
    tick(3);
    chk("epoch_after_second_wrap", epoch_cnt, 2);

    // Advance to ptr=2, then rewind during FETCH.
    push(0, 10, -20, TP, 0, 2);
    pulse_req();
    push(1, 30, 40, TN, 0, 2);
    pulse_req();
    base = strobes;
    req = 1'b1;
    tick(1);
    req = 1'b0;
    rewind = 1'b1;
    tick(1);
    rewind = 1'b0;
    tick(4);
    chk("rewind_no_strobe", strobes - base, 0);
    chk("rewind_epoch", epoch_cnt, 0);
    chk("rewind_hold_x1", $signed(x1), 30);
    chk("rewind_hold_idx", sample_idx, 1);

    // After rewind: restart at idx 0; next epoch carries the new sample 2.
    push(0, 10, -20, TP, 0, 0);
    pulse_req();
    push(1, 30, 40, TN, 0, 0);
    pulse_req();
    push(2, 99, -99, TN, 1, 0);
    pulse_req();
    chk("epoch_after_rewind_wrap", epoch_cnt, 1);

    // Shrinking the set below the pointer forces idx 0 without an epoch bump.
    push(0, 10, -20, TP, 0, 1);
    pulse_req();
    push(1, 30, 40, TN, 0, 1);
    pulse_req();
    n_samples = 5'd2;
    push(0, 10, -20, TP, 0, 1);
    pulse_req();
    chk("shrink_epoch", epoch_cnt, 1);
    push(1, 30, 40, TN, 1, 1);
    pulse_req();
    chk("shrink_wrap_epoch", epoch_cnt, 2);

    tick(3);
    chk("limit_tied_low", limit_hit, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("total_strobes", strobes, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
